out_addr_gen: RTL

OUT_ADDR_GEN -- requirements
Module: out_addr_gen

---
 rtl/out_addr_gen.sv | 129 ++++++++++++
 1 files changed

// File: rtl/out_addr_gen.sv
// Output address generator: streams od+1 channel beats per kernel result and tracks frame position.
// Optional build macro OUT_ADDR_GEN_BACKPRESSURE_EN makes the generator honour out_ready stalls.
module out_addr_gen #(
  parameter int CW = 4,
  parameter int SW = 10,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_init,
  input  logic          k_fin,
  input  logic [CW-1:0] od,
  input  logic [SW-1:0] os,
  input  logic [AW-1:0] base_a,
  input  logic          out_ready,
  output logic          outr,
  output logic [CW-1:0] ra,
  output logic [AW-1:0] oa,
  output logic          out_busy,
  output logic          frame_done,
  output logic          err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM0 = 2'd1,
    S_ARM1 = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_ct;
  logic [SW-1:0] r_wi;
  logic          r_frame_done;
  logic          r_err;

  logic          w_ready;
  logic          w_run;
  logic          w_busy;
  logic          w_xfer;
  logic          w_last_ch;
  logic          w_last_xfer;
  logic          w_wi_wrap;
  logic [AW-1:0] w_prod;

`ifdef OUT_ADDR_GEN_BACKPRESSURE_EN
  assign w_ready = out_ready;
`else
  // Without backpressure every RUN cycle is a transfer.
  logic w_unused_ready;
  assign w_unused_ready = out_ready;
  assign w_ready        = 1'b1;
`endif

  assign w_xfer      = w_run & w_ready;
  assign w_last_ch   = (r_ct == od);
  assign w_last_xfer = w_xfer & w_last_ch;
  assign w_wi_wrap   = (r_wi == (os - SW'(1)));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (k_fin) w_state_nxt = S_ARM0;
      S_ARM0:  w_state_nxt = S_ARM1;
      S_ARM1:  w_state_nxt = S_RUN;
      S_RUN:   if (w_last_xfer) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_run  = (r_state == S_RUN);
    w_busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ct <= '0;
    end else if (r_state == S_ARM1) begin
      r_ct <= '0;
    end else if (w_xfer) begin
      r_ct <= w_last_ch ? '0 : r_ct + CW'(1);
    end
  end

  // s_init overrides the end-of-position advance, including the frame_done it would raise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wi         <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last_xfer & w_wi_wrap & ~s_init;
      if (s_init) begin
        r_wi <= '0;
      end else if (w_last_xfer) begin
        r_wi <= w_wi_wrap ? '0 : r_wi + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (s_init) begin
      r_err <= 1'b0;
    end else if (k_fin && w_busy) begin
      r_err <= 1'b1;
    end
  end

  // Address arithmetic is carried at AW bits so it wraps modulo 2^AW.
  assign w_prod = AW'(r_ct) * AW'(os);
  assign oa     = w_prod + AW'(r_wi) + base_a;

  assign outr       = w_run;
  assign out_busy   = w_busy;
  assign ra         = r_ct;
  assign frame_done = r_frame_done;
  assign err        = r_err;

endmodule
